fc_layer_sched: RTL and testbench
=================================

Name: fc_layer_sched

Overview:
Sequences the single-neuron fully-connected datapath across all output neurons of one layer, one neuron per pass.
- Indexes the weight/bias ROM by row, pulses the datapath start, captures each 32-bit result and streams it out with its index.
- Sits between the feature buffer, which holds the 30-element input vector, and the classifier output stage.
- A watchdog flags a hung datapath.

Parameters:
- N_OUT, 8, number of output neurons (rows); must be ≥1.
- ROW_W, $clog2(N_OUT) (min 1), row index width.
- WAIT_MAX, 15, maximum cycles in S_WAIT before timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous active-high; name kept for codebase consistency
- i_start  in  1  layer start pulse; sampled only in S_IDLE
- o_busy  out  1  high from S_ISSUE through S_WAIT of the last row; upstream holds input vector stable while high
- o_row  out  ROW_W  weight/bias ROM row select; held constant from issue until result captured
- o_fc_start  out  1  one-cycle start pulse to datapath
- i_fc_output  in  32 signed  datapath result
- i_fc_finished  in  1  datapath one-cycle done pulse
- o_out_valid  out  1  one-cycle pulse; o_out_idx/o_out_data valid
- o_out_idx  out  ROW_W  neuron index of o_out_data
- o_out_data  out  32 signed  captured result
- o_done  out  1  one-cycle pulse, coincident with the last o_out_valid
- o_error  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset (synchronous, i_rst_n=1): state S_IDLE; all outputs 0; row counter 0; watchdog 0. Reset mid-layer abandons the layer with no o_done. The datapath shares this reset.
- States:
  - S_IDLE: i_start=1 → S_ISSUE, row=0.
  - S_ISSUE: o_fc_start=1 for exactly this cycle → S_WAIT, watchdog cleared.
  - S_WAIT: watchdog increments each cycle.
    - i_fc_finished=1: register o_out_data=i_fc_output and o_out_idx=row; pulse o_out_valid next cycle.
      - If row==N_OUT-1: assert o_done with that pulse → S_IDLE.
      - Else: row+1 → S_ISSUE.
    - Watchdog reaches WAIT_MAX with no finish: o_error pulse next cycle → S_IDLE. No o_done; row reset to 0.
- Datapath contract: finish arrives 2 cycles after the o_fc_start cycle, and the datapath is idle again one cycle later. The S_ISSUE following capture therefore coincides with datapath idle.
- Timing:
  - Rate is 3 cycles per neuron.
  - With i_start sampled at edge 0: row k is issued in cycle 1+3k, and its o_out_valid is in cycle 4+3k.
  - o_done is in cycle 3·N_OUT+1 (25 for N_OUT=8).
- o_out_data and o_out_idx hold their values between pulses.
- i_start while busy: ignored, not queued.
- i_fc_finished outside S_WAIT: ignored.
- Finish and timeout in the same cycle: finish wins.
- o_row wraps only via return to S_IDLE; it never exceeds N_OUT-1.

Optional Feature:
FC_ARGMAX_EN
- Defined: adds outputs o_class (ROW_W) and o_class_valid (1).
  - A running signed maximum is reset at row 0.
  - A new value replaces the max only if strictly greater, so ties keep the lowest index.
  - o_class_valid pulses with o_done; o_class holds until the next o_done.
  - Timeout or reset clears the running max and does not pulse o_class_valid.
- Undefined: these ports and logic are absent.

Decomposition:
- Package fc_pkg holds:
  - FC_N_IN=30, FC_DATA_W=24, FC_WEIGHT_W=16, FC_OUT_W=32
  - state enum {S_IDLE, S_ISSUE, S_WAIT}
- Sub-module fc_argmax (running max/index tracker) is instantiated only under FC_ARGMAX_EN.

Test Plan:
- Nominal layer: N_OUT=4; real datapath; inputs all 256; row r weights all r+1, bias 0; start at edge 0 → o_out_data 30,60,90,120 with idx 0..3 at cycles 4,7,10,13; o_done at 13; o_busy low at 14.
- Argmax tie (FC_ARGMAX_EN): rows return 50,120,120,-7 → o_class=1, o_class_valid with o_done.
- Negative results: all rows return -5,-3,-9,-3 → o_class=1; o_out_data sign correct at 32 bits.
- Watchdog: i_fc_finished tied 0 → o_error pulse 16 cycles after o_fc_start; no o_out_valid/o_done; state returns to idle. A following start then runs normally.
- Start while busy: second i_start at cycle 5 → exactly 4 results and one o_done; no extra o_fc_start.
- Reset mid-layer: assert i_rst_n at cycle 8 for 1 cycle → all outputs 0 next cycle, no o_done. Restart yields full correct sequence.

Source files
------------

// File: rtl/fc_layer_sched_pkg.sv
// Shared constants and FSM state type for the fully-connected layer scheduler.
package fc_pkg;

    localparam int FC_N_IN     = 30;
    localparam int FC_DATA_W   = 24;
    localparam int FC_WEIGHT_W = 16;
    localparam int FC_OUT_W    = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // A single-row layer still needs a 1-bit row index.
    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_layer_sched_if.sv
// Scheduler-side bus: layer control, datapath handshake and result stream.
// The o_class/o_class_valid pair exists only when FC_ARGMAX_EN is defined.
interface fc_layer_sched_if
    import fc_pkg::*;
#(
    parameter int ROW_W = 3
);
    logic                       i_start;
    logic                       o_busy;
    logic                       o_error;
    logic [ROW_W-1:0]           o_row;
    logic                       o_fc_start;
    logic signed [FC_OUT_W-1:0] i_fc_output;
    logic                       i_fc_finished;
    logic                       o_out_valid;
    logic [ROW_W-1:0]           o_out_idx;
    logic signed [FC_OUT_W-1:0] o_out_data;
    logic                       o_done;
`ifdef FC_ARGMAX_EN
    logic [ROW_W-1:0]           o_class;
    logic                       o_class_valid;
`endif

    modport master (
        input  i_start, i_fc_output, i_fc_finished,
        output o_busy, o_error, o_row, o_fc_start,
               o_out_valid, o_out_idx, o_out_data, o_done
`ifdef FC_ARGMAX_EN
        , output o_class, o_class_valid
`endif
    );

    modport slave (
        output i_start, i_fc_output, i_fc_finished,
        input  o_busy, o_error, o_row, o_fc_start,
               o_out_valid, o_out_idx, o_out_data, o_done
`ifdef FC_ARGMAX_EN
        , input o_class, o_class_valid
`endif
    );

endinterface

// File: rtl/fc_layer_sched_argmax.sv
// Running signed maximum over one layer's results; ties keep the lowest index.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int ROW_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    input  logic                       capture,
    input  logic                       first,
    input  logic                       last,
    input  logic [ROW_W-1:0]           idx,
    input  logic signed [FC_OUT_W-1:0] value,
    output logic [ROW_W-1:0]           class_idx,
    output logic                       class_valid
);

    logic signed [FC_OUT_W-1:0] max_val;
    logic [ROW_W-1:0]           max_idx;
    logic                       take;

    // Row 0 always seeds the maximum so a stale value from a previous layer never wins.
    assign take = first || (value > max_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val     <= '0;
            max_idx     <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (abort) begin
                max_val <= '0;
                max_idx <= '0;
            end else if (capture) begin
                if (take) begin
                    max_val <= value;
                    max_idx <= idx;
                end
                if (last) begin
                    class_idx   <= take ? idx : max_idx;
                    class_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fc_layer_sched.sv
// Steps the single-neuron datapath through every output row of a layer, 3 cycles per row.
// Optional argmax tracker is enabled by defining FC_ARGMAX_EN.
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int N_OUT    = 8,
    parameter int ROW_W    = row_width(N_OUT),
    parameter int WAIT_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fc_layer_sched_if.master  bus
);

    localparam int               WD_W   = $clog2(WAIT_MAX + 1);
    localparam logic [ROW_W-1:0] LAST   = ROW_W'(N_OUT - 1);
    localparam logic [WD_W-1:0]  WD_LIM = WD_W'(WAIT_MAX - 1);

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [WD_W-1:0]   watchdog;
    logic              capture;
    logic              timeout;

    // A finish always beats a simultaneous watchdog expiry.
    assign capture = (state == S_WAIT) && bus.i_fc_finished;
    assign timeout = (state == S_WAIT) && !bus.i_fc_finished && (watchdog == WD_LIM);
    assign bus.o_row = row;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state           <= S_IDLE;
            row             <= '0;
            watchdog        <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_error     <= 1'b0;
            bus.o_fc_start  <= 1'b0;
            bus.o_out_valid <= 1'b0;
            bus.o_out_idx   <= '0;
            bus.o_out_data  <= '0;
            bus.o_done      <= 1'b0;
        end else begin
            bus.o_fc_start  <= 1'b0;
            bus.o_out_valid <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_error     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state          <= S_ISSUE;
                        row            <= '0;
                        bus.o_fc_start <= 1'b1;
                        bus.o_busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    watchdog <= '0;
                end
                S_WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (capture) begin
                        bus.o_out_data  <= bus.i_fc_output;
                        bus.o_out_idx   <= row;
                        bus.o_out_valid <= 1'b1;
                        if (row == LAST) begin
                            bus.o_done <= 1'b1;
                            bus.o_busy <= 1'b0;
                            state      <= S_IDLE;
                            row        <= '0;
                        end else begin
                            // Next issue lines up with the datapath going idle.
                            row            <= row + 1'b1;
                            state          <= S_ISSUE;
                            bus.o_fc_start <= 1'b1;
                        end
                    end else if (timeout) begin
                        bus.o_error <= 1'b1;
                        bus.o_busy  <= 1'b0;
                        state       <= S_IDLE;
                        row         <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FC_ARGMAX_EN
    fc_argmax #(
        .ROW_W (ROW_W)
    ) u_argmax (
        .clk         (i_clk),
        .rst         (i_rst_n),
        .abort       (timeout),
        .capture     (capture),
        .first       (row == '0),
        .last        (row == LAST),
        .idx         (row),
        .value       (bus.i_fc_output),
        .class_idx   (bus.o_class),
        .class_valid (bus.o_class_valid)
    );
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// Self-checking bench for fc_layer_sched with N_OUT=4 and a 2-cycle behavioural datapath.
module tb_fc_layer_sched;
    import fc_pkg::*;

    localparam int N = 4;

    typedef struct {
        bit real_dp;
        bit fin_en;
        int exp_data[4];
        int exp_class;
    } vec_t;

    typedef struct {
        int idx;
        int data;
        int rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fc_layer_sched_if #(.ROW_W(2)) ifc ();

    fc_layer_sched #(
        .N_OUT    (N),
        .ROW_W    (2),
        .WAIT_MAX (15)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    vec_t vecs[5];
    exp_t sb[$];
    int   dp_table[4];
    bit   fin_en = 1'b1;
    int   pass_cnt = 0, total_cnt = 0;
    int   edge_n = 0, start_edge = 0;
    int   valid_cnt = 0, done_cnt = 0, err_cnt = 0, fcs_cnt = 0, cv_cnt = 0, err_rel = 0;

    // Datapath model: row ROM lookup, finish two cycles after the start pulse.
    logic d1, fin;
    logic signed [31:0] res;
    always @(posedge clk) begin
        if (rst) begin
            d1  <= 1'b0;
            fin <= 1'b0;
            res <= '0;
        end else begin
            d1  <= ifc.o_fc_start;
            fin <= d1 && fin_en;
            if (d1) res <= dp_table[ifc.o_row];
        end
    end
    assign ifc.i_fc_finished = fin;
    assign ifc.i_fc_output   = res;

    function automatic int real_fc(input int r);
        longint acc = 0;
        for (int i = 0; i < FC_N_IN; i++) acc += longint'(256) * longint'(r + 1);
        return int'(acc >>> 8);
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard: pops an expected result for each o_out_valid.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (ifc.o_fc_start) fcs_cnt++;
            if (ifc.o_done) done_cnt++;
            if (ifc.o_error) begin
                err_cnt++;
                err_rel = edge_n - start_edge + 1;
            end
`ifdef FC_ARGMAX_EN
            if (ifc.o_class_valid) cv_cnt++;
`endif
            if (ifc.o_out_valid) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_idx", longint'(ifc.o_out_idx), e.idx);
                    checkOutput("out_data", longint'(ifc.o_out_data), e.data);
                    checkOutput("valid_cycle", edge_n - start_edge + 1, e.rel);
                    checkOutput("done_with_last", ifc.o_done, (sb.size() == 0) ? 1 : 0);
`ifdef FC_ARGMAX_EN
                    checkOutput("class_valid", ifc.o_class_valid, (sb.size() == 0) ? 1 : 0);
`endif
                end
            end
        end
    end

    task automatic loadVec(input int v);
        for (int r = 0; r < N; r++) begin
            dp_table[r] = vecs[v].real_dp ? real_fc(r) : vecs[v].exp_data[r];
            if (vecs[v].fin_en) sb.push_back('{idx: r, data: vecs[v].exp_data[r], rel: 4 + 3 * r});
        end
        fin_en    = vecs[v].fin_en;
        valid_cnt = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        fcs_cnt   = 0;
        cv_cnt    = 0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        ifc.i_start = 1'b1;
        start_edge  = edge_n + 1;
        @(negedge clk);
        ifc.i_start = 1'b0;
    endtask

    task automatic waitRel(input int rel);
        for (int i = 0; i < 100 && (edge_n - start_edge + 1) < rel; i++) @(negedge clk);
    endtask

    task automatic waitEnd();
        for (int i = 0; i < 60 && done_cnt == 0 && err_cnt == 0; i++) @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, ifc.o_busy, 0);
        checkOutput({tag, "_fc_start"}, ifc.o_fc_start, 0);
        checkOutput({tag, "_valid"}, ifc.o_out_valid, 0);
        checkOutput({tag, "_done"}, ifc.o_done, 0);
        checkOutput({tag, "_error"}, ifc.o_error, 0);
        checkOutput({tag, "_row"}, longint'(ifc.o_row), 0);
        checkOutput({tag, "_idx"}, longint'(ifc.o_out_idx), 0);
        checkOutput({tag, "_data"}, longint'(ifc.o_out_data), 0);
    endtask

    task automatic runVec(input int v);
        loadVec(v);
        applyStimulus();
        checkOutput("busy_running", ifc.o_busy, 1);
        waitEnd();
        if (vecs[v].fin_en) begin
            checkOutput("done_count", done_cnt, 1);
            checkOutput("valid_count", valid_cnt, N);
            checkOutput("sb_drained", sb.size(), 0);
`ifdef FC_ARGMAX_EN
            checkOutput("class", longint'(ifc.o_class), vecs[v].exp_class);
            checkOutput("class_valid_count", cv_cnt, 1);
`endif
            @(negedge clk);
            checkOutput("busy_after", ifc.o_busy, 0);
            checkOutput("data_hold", longint'(ifc.o_out_data), vecs[v].exp_data[N-1]);
            checkOutput("idx_hold", longint'(ifc.o_out_idx), N - 1);
        end else begin
            checkOutput("error_count", err_cnt, 1);
            checkOutput("error_cycle", err_rel, 17);
            checkOutput("wd_valid_count", valid_cnt, 0);
            checkOutput("wd_done_count", done_cnt, 0);
            checkOutput("wd_busy", ifc.o_busy, 0);
`ifdef FC_ARGMAX_EN
            checkOutput("wd_class_valid", cv_cnt, 0);
`endif
        end
        sb.delete();
        fin_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        vecs[0].real_dp = 1'b1; vecs[0].fin_en = 1'b1;
        vecs[0].exp_data = '{30, 60, 90, 120};     vecs[0].exp_class = 3;
        vecs[1].real_dp = 1'b0; vecs[1].fin_en = 1'b1;
        vecs[1].exp_data = '{50, 120, 120, -7};    vecs[1].exp_class = 1;
        vecs[2].real_dp = 1'b0; vecs[2].fin_en = 1'b1;
        vecs[2].exp_data = '{-5, -3, -9, -3};      vecs[2].exp_class = 1;
        vecs[3].real_dp = 1'b1; vecs[3].fin_en = 1'b0;
        vecs[3].exp_data = '{0, 0, 0, 0};          vecs[3].exp_class = 0;
        vecs[4] = vecs[0];

        ifc.i_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) runVec(v);

        // Second start while busy must be ignored.
        loadVec(0);
        applyStimulus();
        waitRel(4);
        ifc.i_start = 1'b1;
        @(negedge clk);
        ifc.i_start = 1'b0;
        waitEnd();
        repeat (2) @(negedge clk);
        checkOutput("busy_start_valids", valid_cnt, N);
        checkOutput("busy_start_dones", done_cnt, 1);
        checkOutput("busy_start_issues", fcs_cnt, N);
        sb.delete();
        repeat (3) @(negedge clk);

        // Reset in the middle of a layer abandons it.
        loadVec(0);
        applyStimulus();
        waitRel(7);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midreset");
        rst = 1'b0;
        sb.delete();
        repeat (20) @(negedge clk);
        checkOutput("midreset_valids", valid_cnt, 2);
        checkOutput("midreset_dones", done_cnt, 0);
        runVec(0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
